// File: rtl/chandelier_dimmer_ctrl.sv
// rtl/chandelier_dimmer_ctrl.sv - chandelier brightness controller with fault boost, ramp and PWM
module chandelier_dimmer_ctrl #(
  parameter int NUM_BULBS  = 4,
  parameter int LEVEL_W    = 4,
  parameter int NOMINAL    = 10,
  parameter int BOOST_STEP = 2,
  parameter int DEBOUNCE   = 3,
  parameter int RAMP_DIV   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NUM_BULBS-1:0]             bulb_status,
  output logic [NUM_BULBS*LEVEL_W-1:0]     level,
  output logic [NUM_BULBS-1:0]             pwm_out,
  output logic [$clog2(NUM_BULBS+1)-1:0]   fault_count,
  output logic                             all_failed,
  output logic                             settled
);

  localparam int MAX  = (1 << LEVEL_W) - 1;
  localparam int FC_W = $clog2(NUM_BULBS + 1);
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [NUM_BULBS-1:0]               filt;
  logic [NUM_BULBS-1:0]               filt_next;
  logic [NUM_BULBS-1:0][DB_W-1:0]     db_cnt;
  logic [NUM_BULBS-1:0][DB_W-1:0]     db_next;
  logic [NUM_BULBS-1:0][LEVEL_W-1:0]  lvl;
  logic [NUM_BULBS-1:0][LEVEL_W-1:0]  tgt_cur;
  logic [NUM_BULBS-1:0][LEVEL_W-1:0]  tgt_next;
  logic [TK_W-1:0]                    tick_cnt;
  logic                               tick;
  logic [LEVEL_W-1:0]                 pwm_cnt;

  // Number of zero bits in a filtered status vector
  function automatic logic [FC_W-1:0] count_failed(input logic [NUM_BULBS-1:0] f);
    logic [FC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_BULBS; i++) c = c + FC_W'(~f[i]);
    return c;
  endfunction

  // Compensated target, summed in 32 bits so the boost saturates instead of wrapping
  function automatic logic [LEVEL_W-1:0] boosted(input logic [FC_W-1:0] fails);
    logic [31:0] sum;
    sum = 32'(NOMINAL) + 32'(BOOST_STEP) * 32'(fails);
    return (sum > 32'(MAX)) ? LEVEL_W'(MAX) : LEVEL_W'(sum);
  endfunction

  // Next filtered status: a raw difference must persist DEBOUNCE edges to be accepted
  always_comb begin
    filt_next = filt;
    db_next   = db_cnt;
    for (int i = 0; i < NUM_BULBS; i++) begin
      if (bulb_status[i] != filt[i]) begin
        if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          filt_next[i] = bulb_status[i];
          db_next[i]   = '0;
        end else begin
          db_next[i] = db_cnt[i] + DB_W'(1);
        end
      end else begin
        db_next[i] = '0;
      end
    end
  end

  // Targets from the current filter (for settled) and from the next filter (for the ramp step)
  always_comb begin
    tgt_cur  = '0;
    tgt_next = '0;
    for (int i = 0; i < NUM_BULBS; i++) begin
      if (enable && filt[i])      tgt_cur[i]  = boosted(count_failed(filt));
      if (enable && filt_next[i]) tgt_next[i] = boosted(count_failed(filt_next));
    end
  end

  assign tick = (tick_cnt == TK_W'(RAMP_DIV - 1));

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= '1;
      db_cnt <= '0;
    end else begin
      filt   <= filt_next;
      db_cnt <= db_next;
    end
  end

  // Ramp divider: one step opportunity every RAMP_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TK_W'(1);
    end
  end

  // Level ramp; a bulb that drops out is cut to 0 on the same edge its filter flips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
    end else begin
      for (int i = 0; i < NUM_BULBS; i++) begin
        if (!filt_next[i]) begin
          lvl[i] <= '0;
        end else if (tick) begin
          if (lvl[i] < tgt_next[i])      lvl[i] <= lvl[i] + LEVEL_W'(1);
          else if (lvl[i] > tgt_next[i]) lvl[i] <= lvl[i] - LEVEL_W'(1);
        end
      end
    end
  end

  // Free-running PWM period counter, 0..MAX-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt >= LEVEL_W'(MAX - 1)) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + LEVEL_W'(1);
    end
  end

  // Registered PWM compare, gated by the bulb being healthy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_BULBS; i++) begin
        pwm_out[i] <= (pwm_cnt < lvl[i]) & filt[i];
      end
    end
  end

  assign level       = lvl;
  assign fault_count = count_failed(filt);
  assign all_failed  = (filt == '0);
  assign settled     = rst_n && (lvl == tgt_cur);

endmodule

// File: tb/tb_chandelier_dimmer_ctrl.sv
// tb/tb_chandelier_dimmer_ctrl.sv - self-checking bench for chandelier_dimmer_ctrl
module tb_chandelier_dimmer_ctrl;
  localparam int N = 4, LW = 4, NOM = 10, BST = 2, DEB = 3, RD = 4, MAXL = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b1;
  logic [N-1:0]     bulb_status = '1;
  logic [N*LW-1:0]  level;
  logic [N-1:0]     pwm_out;
  logic [2:0]       fault_count;
  logic             all_failed;
  logic             settled;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  int m_filt[N], m_cnt[N], m_lvl[N], m_pwm[N];
  int m_tick, m_pcnt, t, acc;
  bit found;

  always #5 clk = ~clk;

  chandelier_dimmer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bulb_status(bulb_status),
    .level(level), .pwm_out(pwm_out), .fault_count(fault_count),
    .all_failed(all_failed), .settled(settled)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int i);
    return int'(level[i*LW +: LW]);
  endfunction

  function automatic int m_faults();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_filt[i] == 0) c++;
    return c;
  endfunction

  function automatic int m_target(input int i, input bit en);
    int v;
    if (!en || m_filt[i] == 0) return 0;
    v = NOM + BST * m_faults();
    return (v > MAXL) ? MAXL : v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_filt[i] = 1; m_cnt[i] = 0; m_lvl[i] = 0; m_pwm[i] = 0;
    end
    m_tick = 0; m_pcnt = 0;
  endtask

  always @(negedge rst_n) m_reset();

  // Reference model, advanced once per rising edge from the spec's rules
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) m_pwm[i] = (m_pcnt < m_lvl[i] && m_filt[i] == 1) ? 1 : 0;
      for (int i = 0; i < N; i++) begin
        if (int'(bulb_status[i]) != m_filt[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin m_filt[i] = int'(bulb_status[i]); m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_filt[i] == 0) m_lvl[i] = 0;
        else if (m_tick == RD - 1) begin
          t = m_target(i, enable);
          if (m_lvl[i] < t) m_lvl[i]++;
          else if (m_lvl[i] > t) m_lvl[i]--;
        end
      end
      m_tick = (m_tick + 1) % RD;
      m_pcnt = (m_pcnt + 1) % MAXL;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      bit s;
      s = rst_n;
      for (int i = 0; i < N; i++) begin
        check($sformatf("level[%0d]", i), lvl_of(i), m_lvl[i]);
        check($sformatf("pwm_out[%0d]", i), int'(pwm_out[i]), m_pwm[i]);
        if (m_lvl[i] != m_target(i, enable)) s = 1'b0;
      end
      check("fault_count", int'(fault_count), m_faults());
      check("all_failed", int'(all_failed), (m_faults() == N) ? 1 : 0);
      check("settled", int'(settled), int'(s));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    m_reset();
    run_cmp = 1'b1;
    step(2);
    check("reset level", int'(level), 0);
    check("reset pwm", int'(pwm_out), 0);
    check("reset fault_count", int'(fault_count), 0);
    check("reset all_failed", int'(all_failed), 0);
    check("reset settled", int'(settled), 0);
    rst_n = 1'b1;

    // Ramp up to nominal
    step(45);
    for (int i = 0; i < N; i++) check($sformatf("nominal level[%0d]", i), lvl_of(i), 10);
    check("nominal settled", int'(settled), 1);
    acc = 0;
    for (int k = 0; k < 15; k++) begin step(1); acc += int'(pwm_out[0]); end
    check("pwm duty 10/15", acc, 10);

    // Short glitch is filtered out
    bulb_status[2] = 1'b0;
    step(2);
    bulb_status[2] = 1'b1;
    step(5);
    check("glitch fault_count", int'(fault_count), 0);
    check("glitch level[2]", lvl_of(2), 10);

    // Sustained failure of bulb 2
    bulb_status[2] = 1'b0;
    step(2);
    check("fail pre fault_count", int'(fault_count), 0);
    step(1);
    check("fail fault_count", int'(fault_count), 1);
    check("fail level[2]", lvl_of(2), 0);
    step(10);
    check("boost level[0]", lvl_of(0), 12);
    check("boost pwm_out[2]", int'(pwm_out[2]), 0);

    // Three failed -> saturate at MAX
    bulb_status = 4'b0001;
    step(30);
    check("sat level[0]", lvl_of(0), 15);
    check("sat fault_count", int'(fault_count), 3);
    acc = 0;
    for (int k = 0; k < 20; k++) begin step(1); acc += int'(pwm_out[0]); end
    check("sat pwm constant", acc, 20);

    // All failed, then repair with enable low
    bulb_status = 4'b0000;
    step(4);
    check("all_failed", int'(all_failed), 1);
    check("all fault_count", int'(fault_count), 4);
    check("all level", int'(level), 0);
    check("all pwm", int'(pwm_out), 0);
    enable = 1'b0;
    bulb_status = 4'b1111;
    step(5);
    check("off level", int'(level), 0);
    check("off settled", int'(settled), 1);
    check("off fault_count", int'(fault_count), 0);

    // Ramp up, reverse mid-ramp, then async reset
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step(1);
      if (lvl_of(0) == 5) found = 1'b1;
    end
    check("reach level 5", int'(found), 1);
    enable = 1'b0;
    step(12);
    check("ramp down level[0]", lvl_of(0), 2);
    rst_n = 1'b0;
    #1;
    check("async reset level", int'(level), 0);
    check("async reset pwm", int'(pwm_out), 0);
    check("async reset settled", int'(settled), 0);
    step(2);
    enable = 1'b1;
    rst_n = 1'b1;
    step(50);
    check("re-ramp level[3]", lvl_of(3), 10);

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chandelier_dimmer_ctrl.md
Name: chandelier_dimmer_ctrl

Overview:
Parametrised chandelier brightness controller for NUM_BULBS bulbs.
- Debounces the per-bulb health inputs and counts failed bulbs.
- Raises the brightness target of the surviving bulbs to compensate for failed ones.
- Ramps each bulb's level toward its target and drives one PWM output per bulb.
- Sits between the bulb-sense inputs and the lamp drivers.

Parameters:
NUM_BULBS, 4, number of bulbs/channels (>=1)
LEVEL_W, 4, brightness level width; MAX = 2^LEVEL_W-1
NOMINAL, 10, target level when no bulb is failed (<= MAX)
BOOST_STEP, 2, added to the target per failed bulb
DEBOUNCE, 3, consecutive cycles a raw status change must persist (>=1)
RAMP_DIV, 4, clock cycles per one-step level change (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = lights on; 0 = ramp all bulbs to 0
bulb_status  in  NUM_BULBS  raw health, 1 = working
level  out  NUM_BULBS*LEVEL_W  current per-bulb level; bulb i occupies bits [i*LEVEL_W +: LEVEL_W]
pwm_out  out  NUM_BULBS  per-bulb PWM drive, registered
fault_count  out  $clog2(NUM_BULBS+1)  number of debounced failed bulbs
all_failed  out  1  1 when every debounced status = 0
settled  out  1  1 when every level equals its target

Behaviour:
- Reset: while rst_n=0, asynchronously and immediately:
  - filtered status = all 1s
  - debounce counters = 0, ramp tick counter = 0, PWM counter = 0
  - level = 0, pwm_out = 0
  - fault_count = 0, all_failed = 0, settled = 0
- Clocking: after reset release, all state updates on the rising clk edge only.
- Debounce (per bulb):
  - If raw != filtered, the bulb's counter increments. On the edge where it would reach DEBOUNCE, filtered takes the raw value and the counter clears.
  - If raw == filtered, the counter clears. A glitch shorter than DEBOUNCE cycles never reaches filtered.
  - Latency: filtered updates on the DEBOUNCE-th consecutive sampling edge.
- Fault status:
  - fault_count = popcount(~filtered), driven combinationally from the filtered register.
  - all_failed = (filtered == 0).
- Target per bulb:
  - Failed bulb (filtered=0): target 0.
  - enable=0: target 0.
  - Otherwise: target = min(NOMINAL + BOOST_STEP*fault_count, MAX). Compute in a width wide enough that the sum cannot overflow before saturating.
- Ramp:
  - Tick counter runs 0..RAMP_DIV-1 and wraps; tick = (counter == RAMP_DIV-1).
  - On a tick, each working bulb's level moves one step toward its target; no change if already equal.
  - A bulb whose filtered status goes to 0 has its level forced to 0 on the same edge the filter flips, with no ramp.
  - A repaired bulb ramps up from 0.
- PWM:
  - Free-running counter 0..MAX-1, period MAX cycles.
  - pwm_out[i] is registered as (pwm_cnt < level[i]) & filtered[i].
  - Level MAX gives constant 1; level 0 gives constant 0. One-cycle latency from level to pwm_out.
- settled: combinational, 1 iff level[i] == target[i] for all i. This includes the all-zero case with enable=0.
- Simultaneous events: fault flips and target changes in the same cycle as a tick use the new target for that tick's step. enable toggling mid-ramp reverses direction at the next tick.
- Reset mid-operation: outputs return to their reset values immediately. After release, levels ramp again from 0.

Test Plan (defaults: NUM_BULBS=4, LEVEL_W=4, NOMINAL=10, BOOST_STEP=2, DEBOUNCE=3, RAMP_DIV=4):
1. Release reset, status=1111, enable=1 -> each level steps +1 every 4 cycles, reaching 10 after 10 ticks (40 cycles). settled=1, fault_count=0, each pwm_out high 10 of every 15 cycles.
2. Settled state; bulb_status[2]=0 for 2 cycles, then back to 1 -> filtered unchanged, fault_count stays 0, levels stay 10.
3. Settled state; bulb_status[2]=0 held -> on the 3rd edge, fault_count=1, level[2]=0 at once, pwm_out[2]=0 from the next cycle. Bulbs 0, 1, 3 ramp 10->12 over 2 ticks.
4. Bulbs 1, 2, 3 failed (status=0001) -> target = min(10+6, 15) = 15; level[0] reaches 15 and pwm_out[0] is constant 1.
5. status=0000 -> all_failed=1, fault_count=4, all levels and pwm_out = 0. Then restore 1111 with enable=0 -> levels stay 0, settled=1.
6. Enable=1 mid-ramp at level 5, drop enable -> level ramps down from the next tick. Assert rst_n=0 asynchronously mid-ramp -> level and pwm_out are 0 before the next clk edge.
